sine_burst_ctrl: RTL and testbench
==================================

# sine_burst_ctrl

Sequencer for the sine synthesis datapath: generates the sine ROM address and read strobe at a programmable sample rate, and plays either a fixed number of full sine periods (burst) or runs continuously until stopped. It sits between the control logic and the ROM/DAC chain in the 300 MHz domain. It replaces the free-running tick counter and address register with a start/busy/done handshake.

## Interface
- ADDR_W, 6, ROM address width; one sine period = 2^ADDR_W samples
- DIV_W, 16, width of the sample-rate divider
- CNT_W, 8, width of the period counter and burst length
- clk  in  1  clock (300 MHz domain)
- rst  in  1  synchronous reset, active-high
- start  in  1  start request, sampled only in IDLE
- stop  in  1  stop request, sampled only in RUN
- div_in  in  DIV_W  clocks per sample; 0 is treated as 1
- ncyc_in  in  CNT_W  sine periods per burst; 0 = continuous
- rom_en  out  1  one-cycle ROM read strobe (drives ROM and DAC enable)
- rom_addr  out  ADDR_W  ROM address, valid while rom_en=1
- busy  out  1  high in RUN and STOPPING
- done  out  1  one-cycle pulse on burst completion or stop
- cyc_cnt  out  CNT_W  completed periods since last start

## Operation
- All outputs registered. Reset values: rom_en=0, rom_addr=0, busy=0, done=0, cyc_cnt=0; state IDLE.
- States: IDLE, RUN, STOPPING.
- IDLE: start=1 latches div_q=max(div_in,1) and ncyc_q=ncyc_in, clears cyc_cnt and divider, sets rom_addr=0, enters RUN. Inputs div_in/ncyc_in are ignored outside this cycle.
- RUN: internal divider counts 0..div_q-1; rom_en=1 on the cycle divider=0 (first RUN cycle included). After each strobe, rom_addr increments modulo 2^ADDR_W.
- Period end: a strobe at rom_addr=2^ADDR_W-1 completes one period; cyc_cnt increments (wraps modulo 2^CNT_W in continuous mode).
- Burst end: if ncyc_q≠0 and the completed period makes cyc_cnt=ncyc_q, next state IDLE with done=1, busy=0, rom_addr=0.
- STOPPING: entered on stop=1 in RUN; strobing continues unchanged until the current period completes, then IDLE with done=1. If stop arrives on the final strobe of a period, completion happens on that period (no extra period).
- start while busy: ignored. stop in IDLE: ignored. start and stop in the same IDLE cycle: start taken, stop dropped.
- rst mid-burst: all state and outputs to reset values on the next edge; no done pulse.

## Timing
- start sampled at edge T: busy=1, rom_en=1, rom_addr=0 from T+1.
- Strobe k (k≥0) at cycle T+1+k·div_q with rom_addr = k mod 2^ADDR_W; rom_en=0 in between when div_q>1; div_q=1 gives a strobe every cycle.
- N-period burst: last strobe at T+1+(N·2^ADDR_W−1)·div_q; done=1, busy=0 the following cycle, independent of div_q.
- A new start is accepted in the cycle done=1 (state already IDLE).
- ROM read latency is external; the controller does not wait for data.

## Configuration
- SINE_BURST_ABORT_EN defined: stop in RUN aborts immediately: next cycle IDLE, busy=0, rom_en=0, rom_addr=0, done=1; cyc_cnt holds completed periods only; STOPPING state not built.
- Undefined: graceful stop via STOPPING as described above.

## Test plan
- Reset: hold rst 3 cycles mid-run -> all outputs 0, no done; rom_en stays 0 until next start.
- Burst: div_in=1, ncyc_in=2 -> 128 consecutive strobes, addresses 0..63,0..63; done 1 cycle after addr 63 of period 2; cyc_cnt=2 held.
- Divider: div_in=4, ncyc_in=1 -> strobes every 4th cycle, 64 strobes, done at T+1+63·4+1; div_in=0 behaves as div_in=1.
- Continuous + stop: ncyc_in=0, div_in=2, stop at addr 10 -> strobes continue to addr 63, then done; cyc_cnt=1 (with SINE_BURST_ABORT_EN: IDLE next cycle, done=1, cyc_cnt=0).
- Handshake corners: start while busy ignored (addresses unaffected); start+stop in IDLE -> burst runs; restart in done cycle -> rom_addr=0 strobe next cycle.
- Continuous wrap: CNT_W=2, ncyc_in=0 -> cyc_cnt goes 1,2,3,0,1, no done pulse.

Source files
------------

// File: rtl/sine_burst_ctrl.sv
// Sine ROM address/strobe sequencer with burst and continuous playback.
// SINE_BURST_ABORT_EN selects immediate abort on stop instead of finishing the period.
module sine_burst_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  div_in,
    input  logic [CNT_W-1:0]  ncyc_in,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cyc_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1
`ifndef SINE_BURST_ABORT_EN
        ,
        STOPPING = 2'd2
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  dcnt_q, dcnt_d;
    logic [CNT_W-1:0]  ncyc_q, ncyc_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              period_end;
    logic              burst_end;
    logic              finish;
    logic [CNT_W-1:0]  cyc_inc;
    logic [DIV_W-1:0]  dcnt_nxt;

    always_comb begin
        cyc_inc    = cyc_q + CNT_W'(1);
        period_end = en_q && (addr_q == {ADDR_W{1'b1}});
        burst_end  = period_end && (ncyc_q != '0) && (cyc_inc == ncyc_q);
        if (dcnt_q == div_q - DIV_W'(1))
            dcnt_nxt = '0;
        else
            dcnt_nxt = dcnt_q + DIV_W'(1);
        finish = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        dcnt_d  = dcnt_q;
        ncyc_d  = ncyc_q;
        cyc_d   = cyc_q;
        addr_d  = addr_q;
        en_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    div_d   = (div_in == '0) ? DIV_W'(1) : div_in;
                    ncyc_d  = ncyc_in;
                    cyc_d   = '0;
                    dcnt_d  = '0;
                    addr_d  = '0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                // Advance the sample schedule; the strobe cycle bumps the address.
                dcnt_d = dcnt_nxt;
                en_d   = (dcnt_nxt == '0);
                if (en_q)
                    addr_d = addr_q + ADDR_W'(1);
                if (period_end)
                    cyc_d = cyc_inc;
`ifdef SINE_BURST_ABORT_EN
                if (burst_end || stop) begin
`else
                if (burst_end || (period_end &&
                    (stop || state_q == STOPPING))) begin
`endif
                    state_d = IDLE;
                    dcnt_d  = '0;
                    addr_d  = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
`ifndef SINE_BURST_ABORT_EN
                else if (stop && state_q == RUN) begin
                    state_d = STOPPING;
                end
`endif
                if (state_q != RUN
`ifndef SINE_BURST_ABORT_EN
                    && state_q != STOPPING
`endif
                ) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    addr_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= DIV_W'(1);
            dcnt_q  <= '0;
            ncyc_q  <= '0;
            cyc_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            dcnt_q  <= dcnt_d;
            ncyc_q  <= ncyc_d;
            cyc_q   <= cyc_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    logic unused_finish;
    assign unused_finish = finish;

    assign rom_en   = en_q;
    assign rom_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cyc_cnt  = cyc_q;

endmodule

// File: tb/tb_sine_burst_ctrl.sv
// Randomized bench for sine_burst_ctrl against a cycle-schedule model.
// Expectations follow SINE_BURST_ABORT_EN when it is defined.
module tb_sine_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [15:0] div_in;
    logic [7:0]  ncyc_in;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic        busy, done;
    logic [7:0]  cyc_cnt;

    logic        start2, stop2;
    logic [15:0] div_in2;
    logic [1:0]  ncyc2;
    logic        rom_en2;
    logic [5:0]  rom_addr2;
    logic        busy2, done2;
    logic [1:0]  cyc_cnt2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sine_burst_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .div_in(div_in), .ncyc_in(ncyc_in),
        .rom_en(rom_en), .rom_addr(rom_addr), .busy(busy),
        .done(done), .cyc_cnt(cyc_cnt)
    );

    sine_burst_ctrl #(.ADDR_W(6), .DIV_W(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop2),
        .div_in(div_in2), .ncyc_in(ncyc2),
        .rom_en(rom_en2), .rom_addr(rom_addr2), .busy(busy2),
        .done(done2), .cyc_cnt(cyc_cnt2)
    );

    task automatic kick(input int d, input int n, input bit with_stop);
        @(negedge clk);
        div_in  = 16'(d);
        ncyc_in = 8'(n);
        start   = 1'b1;
        stop    = with_stop;
    endtask

    // Natural last-strobe cycle (relative to start edge) of an n-period burst.
    function automatic int nat_last(input int d_in, input int n);
        int d;
        d = (d_in == 0) ? 1 : d_in;
        return 1 + (n * 64 - 1) * d;
    endfunction

    // Caller has already driven start at the current negedge.
    task automatic run_case(input string name, input int d_in, input int n_in,
                            input int stop_t, input bit restart,
                            input int rd, input int rn);
        int d, total, last_t, done_t, n_s, g, nb, ecyc, eaddr;
        logic een;
        d = (d_in == 0) ? 1 : d_in;
        total = n_in * 64;
        last_t = 1 + (total - 1) * d;
        if (stop_t > 0) begin
            n_s = (stop_t - 1) / d + 1;
`ifdef SINE_BURST_ABORT_EN
            total = n_s;
            last_t = stop_t;
`else
            g = ((n_s + 63) / 64) * 64;
            if (n_in == 0 || g < total)
                total = g;
            last_t = 1 + (total - 1) * d;
`endif
        end
        done_t = last_t + 1;
        @(posedge clk);
        for (int t = 1; t <= done_t; t++) begin
            @(negedge clk);
            if (t <= last_t)
                start = ($urandom_range(0, 7) == 0);
            else
                start = 1'b0;
            stop = (t == stop_t);
            if (t == 1) begin
                div_in  = 16'($urandom);
                ncyc_in = 8'($urandom);
            end
            if (restart && t == done_t) begin
                start   = 1'b1;
                div_in  = 16'(rd);
                ncyc_in = 8'(rn);
            end
            een = (t <= last_t) && ((t - 1) % d == 0);
            nb = (t <= 1) ? 0 : ((t - 2) / d + 1);
            if (nb > total)
                nb = total;
            ecyc = (nb / 64) % 256;
            eaddr = (t == done_t) ? 0 : (((t - 1) / d) % 64);
            vectors += 4;
            if (rom_en !== een) begin
                miscompares++;
                $display("FAIL %s t=%0d rom_en got %b exp %b",
                         name, t, rom_en, een);
            end
            if (busy !== (t <= last_t)) begin
                miscompares++;
                $display("FAIL %s t=%0d busy got %b exp %b",
                         name, t, busy, (t <= last_t));
            end
            if (done !== (t == done_t)) begin
                miscompares++;
                $display("FAIL %s t=%0d done got %b exp %b",
                         name, t, done, (t == done_t));
            end
            if (cyc_cnt !== 8'(ecyc)) begin
                miscompares++;
                $display("FAIL %s t=%0d cyc_cnt got %0d exp %0d",
                         name, t, cyc_cnt, ecyc);
            end
            if (een || t == done_t) begin
                vectors++;
                if (rom_addr !== 6'(eaddr)) begin
                    miscompares++;
                    $display("FAIL %s t=%0d rom_addr got %0d exp %0d",
                             name, t, rom_addr, eaddr);
                end
            end
        end
        stop = 1'b0;
        if (!restart)
            start = 1'b0;
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({rom_en, rom_addr, busy, done, cyc_cnt} !== 17'd0) begin
            miscompares++;
            $display("FAIL %s en=%b addr=%0d busy=%b done=%b cyc=%0d exp all 0",
                     name, rom_en, rom_addr, busy, done, cyc_cnt);
        end
        vectors++;
        if ({rom_en2, rom_addr2, busy2, done2, cyc_cnt2} !== 11'd0) begin
            miscompares++;
            $display("FAIL %s dut2 outputs not zero", name);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; div_in = '0; ncyc_in = '0;
        start2 = 1'b0; stop2 = 1'b0; div_in2 = '0; ncyc2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_init");
        rst = 1'b0;
        kick(1, 2, 1'b0);
        repeat (40) begin
            @(negedge clk);
            start = 1'b0;
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre busy got %b exp 1", busy);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("reset_mid");
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_zero("reset_after");
        end
    endtask

    task automatic test_burst;
        kick(1, 2, 1'b0);
        run_case("burst", 1, 2, 0, 1'b0, 0, 0);
        @(negedge clk);
        vectors++;
        if (cyc_cnt !== 8'd2 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_hold cyc_cnt got %0d done %b exp 2 0",
                     cyc_cnt, done);
        end
    endtask

    task automatic test_divider;
        kick(4, 1, 1'b0);
        run_case("div4", 4, 1, 0, 1'b0, 0, 0);
        kick(0, 1, 1'b0);
        run_case("div0", 0, 1, 0, 1'b0, 0, 0);
    endtask

    task automatic test_stop;
        kick(2, 0, 1'b0);
        run_case("stop_addr10", 2, 0, 21, 1'b0, 0, 0);
        kick(1, 0, 1'b0);
        run_case("stop_last", 1, 0, 64, 1'b0, 0, 0);
        kick(3, 3, 1'b0);
        run_case("stop_burst", 3, 3, 250, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back;
        kick(1, 1, 1'b1);
        run_case("start_stop_idle", 1, 1, 0, 1'b0, 0, 0);
        kick(3, 1, 1'b0);
        run_case("restart_a", 3, 1, 0, 1'b1, 1, 1);
        run_case("restart_b", 1, 1, 0, 1'b0, 0, 0);
    endtask

    task automatic test_random;
        int d, n, st;
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(0, 4);
            n = $urandom_range(1, 2);
            st = 0;
            if ($urandom_range(0, 1) == 1)
                st = $urandom_range(1, nat_last(d, n) - 1);
            kick(d, n, 1'($urandom_range(0, 1)));
            run_case("random", d, n, st, 1'b0, 0, 0);
        end
    endtask

    task automatic test_wrap;
        int ecyc;
        bit seen;
        @(negedge clk);
        start2 = 1'b1; div_in2 = 16'd1; ncyc2 = 2'd0;
        @(posedge clk);
        for (int t = 1; t <= 64 * 5 + 5; t++) begin
            @(negedge clk);
            start2 = 1'b0;
            ecyc = ((t - 1) / 64) % 4;
            vectors += 3;
            if (cyc_cnt2 !== 2'(ecyc)) begin
                miscompares++;
                $display("FAIL wrap t=%0d cyc_cnt got %0d exp %0d",
                         t, cyc_cnt2, ecyc);
            end
            if (done2 !== 1'b0 || busy2 !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap t=%0d done/busy got %b%b exp 01",
                         t, done2, busy2);
            end
            if (rom_en2 !== 1'b1 || rom_addr2 !== 6'((t - 1) % 64)) begin
                miscompares++;
                $display("FAIL wrap t=%0d en/addr got %b/%0d exp 1/%0d",
                         t, rom_en2, rom_addr2, (t - 1) % 64);
            end
        end
        stop2 = 1'b1;
        @(negedge clk);
        stop2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done2 === 1'b1)
                seen = 1'b1;
            else
                @(negedge clk);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL wrap_stop done got 0 exp 1 within 200 cycles");
        end
    endtask

    initial begin
        test_reset;
        test_burst;
        test_divider;
        test_stop;
        test_back_to_back;
        test_random;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
